// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing: pixel counters, frame strobes and a one-stage
// registered TinyVGA output with syncs aligned to the blanked colour.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [5:0] rgb_in,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       video_active,
    output logic       frame_start,
    output logic       vblank_start,
    output logic [7:0] frame_count,
    output logic [7:0] vga_out
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_END  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_END  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    if (H_TOTAL > 1023) begin : g_h_chk
        $error("vga_timing_gen: horizontal total exceeds 10 bits");
    end
    if (V_TOTAL > 1023) begin : g_v_chk
        $error("vga_timing_gen: vertical total exceeds 10 bits");
    end

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_last;
    logic       v_last;
    logic       hs0;
    logic       vs0;
    logic [5:0] rgb_q;
    logic       hsync_n;
    logic       vsync_n;

    assign pix_x  = h_cnt;
    assign pix_y  = v_cnt;
    assign h_last = (h_cnt == H_END);
    assign v_last = (v_cnt == V_END);

    assign video_active = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    assign frame_start  = (h_cnt == 10'd0) && (v_cnt == 10'd0);
    assign vblank_start = (h_cnt == 10'd0) && (v_cnt == V_VIS);

    assign hs0 = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    assign vs0 = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_count <= '0;
        end else if (ena) begin
            if (h_last) begin
                h_cnt <= '0;
                if (v_last) begin
                    v_cnt       <= '0;
                    frame_count <= frame_count + 8'd1;
                end else begin
                    v_cnt <= v_cnt + 10'd1;
                end
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Colour and syncs share this stage so they leave the pins together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rgb_q   <= '0;
            hsync_n <= 1'b1;
            vsync_n <= 1'b1;
        end else if (ena) begin
            rgb_q   <= video_active ? rgb_in : 6'd0;
            hsync_n <= ~hs0;
            vsync_n <= ~vs0;
        end
    end

    assign vga_out = {hsync_n, rgb_q[0], rgb_q[2], rgb_q[4],
                      vsync_n, rgb_q[1], rgb_q[3], rgb_q[5]};

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size instance for line timing, a
// shrunken instance for frame timing and frame counter wrap.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, ena;
    logic [5:0] rgb_in;
    logic [9:0] pix_x, pix_y;
    logic       video_active, frame_start, vblank_start;
    logic [7:0] frame_count, vga_out;

    logic       rst_s, ena_s;
    logic [5:0] rgb_s;
    logic [9:0] px_s, py_s;
    logic       va_s, fs_s, vb_s;
    logic [7:0] fc_s, vga_s;

    vga_timing_gen dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .rgb_in(rgb_in),
        .pix_x(pix_x), .pix_y(pix_y), .video_active(video_active),
        .frame_start(frame_start), .vblank_start(vblank_start),
        .frame_count(frame_count), .vga_out(vga_out)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_s (
        .clk(clk), .rst_n(rst_s), .ena(ena_s), .rgb_in(rgb_s),
        .pix_x(px_s), .pix_y(py_s), .video_active(va_s),
        .frame_start(fs_s), .vblank_start(vb_s),
        .frame_count(fc_s), .vga_out(vga_s)
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] qb[$];
    logic [7:0] qs[$];

    typedef struct {
        int         x;
        int         y;
        logic [5:0] rgb;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pack(input logic hs_n, input logic vs_n,
                                        input logic [5:0] c);
        return {hs_n, c[0], c[2], c[4], vs_n, c[1], c[3], c[5]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto_b(input int x, input int y, input int limit);
        int n = 0;
        while (!(pix_x == 10'(x) && pix_y == 10'(y)) && n < limit) begin
            step();
            n++;
        end
        check("goto_x", 32'(pix_x), x);
        check("goto_y", 32'(pix_y), y);
    endtask

    task automatic run_big();
        logic [5:0] r;
        logic [7:0] e;
        int hs_first = -1, hs_last = -1, hs_cnt = 0;
        rst_n = 1'b0; ena = 1'b1; rgb_in = 6'h3F;
        repeat (3) step();
        check("rst_vga", 32'(vga_out), 32'h88);
        check("rst_x", 32'(pix_x), 0);
        check("rst_y", 32'(pix_y), 0);
        check("rst_fc", 32'(frame_count), 0);
        rst_n = 1'b1;
        check("c0_fs", 32'(frame_start), 1);
        check("c0_va", 32'(video_active), 1);
        check("c0_vb", 32'(vblank_start), 0);
        for (int c = 0; c < 800; c++) begin
            r = (c >= 630 && c < 760) ? 6'h3F : 6'($urandom);
            rgb_in = r;
            qb.push_back(pack(!(c >= 656 && c < 752), 1'b1,
                              (c < 640) ? r : 6'd0));
            check("line_x", 32'(pix_x), c);
            step();
            e = qb.pop_front();
            check("line_vga", 32'(vga_out), 32'(e));
            if (!vga_out[7]) begin
                if (hs_first < 0) hs_first = c + 1;
                hs_last = c + 1;
                hs_cnt++;
            end
        end
        check("eol_x", 32'(pix_x), 0);
        check("eol_y", 32'(pix_y), 1);
        check("hs_first", hs_first, 657);
        check("hs_last", hs_last, 752);
        check("hs_len", hs_cnt, 96);
        foreach (tbl[i]) begin
            goto_b(tbl[i].x, tbl[i].y, 2000);
            rgb_in = tbl[i].rgb;
            qb.push_back(tbl[i].exp);
            step();
            e = qb.pop_front();
            check("vec_vga", 32'(vga_out), 32'(e));
        end
        goto_b(122, 45, 40000);
        rgb_in = 6'h15;
        step();
        check("hold_pre", 32'(vga_out), 32'hF8);
        ena = 1'b0;
        rgb_in = 6'h3F;
        repeat (10) begin
            step();
            check("hold_x", 32'(pix_x), 123);
            check("hold_y", 32'(pix_y), 45);
            check("hold_vga", 32'(vga_out), 32'hF8);
        end
        ena = 1'b1;
        step();
        check("resume_x", 32'(pix_x), 124);
        check("resume_vga", 32'(vga_out), 32'hFF);
        goto_b(300, 46, 2000);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mrst_x", 32'(pix_x), 0);
        check("mrst_y", 32'(pix_y), 0);
        check("mrst_fs", 32'(frame_start), 1);
        check("mrst_vga", 32'(vga_out), 32'h88);
        step();
        check("mrst_x1", 32'(pix_x), 1);
    endtask

    task automatic run_small();
        logic [5:0] r;
        logic [7:0] e;
        int x, y, n;
        int fs_n = 0, fs_at = -1, vb_n = 0, vb_at = -1;
        int vs_n = 0, vs_first = -1;
        rst_s = 1'b0; ena_s = 1'b1; rgb_s = 6'h3F;
        repeat (2) step();
        rst_s = 1'b1;
        for (int c = 0; c < 128; c++) begin
            x = c % 16;
            y = c / 16;
            r = 6'($urandom);
            rgb_s = r;
            if (fs_s) begin fs_n++; fs_at = c; end
            if (vb_s) begin vb_n++; vb_at = c; end
            qs.push_back(pack(!(x >= 10 && x < 14), !(y >= 5 && y < 7),
                              (x < 8 && y < 4) ? r : 6'd0));
            step();
            e = qs.pop_front();
            check("frm_vga", 32'(vga_s), 32'(e));
            if (!vga_s[3]) begin
                if (vs_first < 0) vs_first = c + 1;
                vs_n++;
            end
        end
        check("fs_count", fs_n, 1);
        check("fs_at", fs_at, 0);
        check("vb_count", vb_n, 1);
        check("vb_at", vb_at, 64);
        check("vs_len", vs_n, 32);
        check("vs_first", vs_first, 81);
        check("frm_fc", 32'(fc_s), 1);
        check("frm_fs", 32'(fs_s), 1);
        n = 0;
        while (fc_s != 8'd255 && n < 40000) begin
            step();
            n++;
        end
        check("fc_reach", 32'(fc_s), 255);
        check("fc255_fs", 32'(fs_s), 1);
        repeat (127) step();
        check("fc_pre_x", 32'(px_s), 15);
        check("fc_pre_y", 32'(py_s), 7);
        check("fc_pre", 32'(fc_s), 255);
        step();
        check("fc_wrap", 32'(fc_s), 0);
        check("fc_wrap_fs", 32'(fs_s), 1);
    endtask

    initial begin
        tbl[0]  = '{0,   1, 6'b100000, 8'h89};
        tbl[1]  = '{1,   1, 6'b010000, 8'h98};
        tbl[2]  = '{2,   1, 6'b001000, 8'h8A};
        tbl[3]  = '{3,   1, 6'b000100, 8'hA8};
        tbl[4]  = '{4,   1, 6'b000010, 8'h8C};
        tbl[5]  = '{5,   1, 6'b000001, 8'hC8};
        tbl[6]  = '{639, 1, 6'h3F,     8'hFF};
        tbl[7]  = '{640, 1, 6'h3F,     8'h88};
        tbl[8]  = '{655, 1, 6'h3F,     8'h88};
        tbl[9]  = '{656, 1, 6'h3F,     8'h08};
        tbl[10] = '{700, 1, 6'h3F,     8'h08};
        tbl[11] = '{751, 1, 6'h3F,     8'h08};
        tbl[12] = '{752, 1, 6'h3F,     8'h88};
        tbl[13] = '{0,   2, 6'h3F,     8'hFF};
        fork
            run_big();
            run_small();
        join
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
